// File: rtl/adc_stream_pkg.sv
// Shared definitions for the ADC multi-stream packetiser: FSM states,
// header field positions and per-set word count.
package adc_stream_pkg;

    localparam int PKT_HDR_WORDS = 2;
    localparam int HDR_SEQ_LSB   = 0;
    localparam int HDR_NUM_LSB   = 32;
    localparam int HDR_MASK_LSB  = 48;
    localparam int HDR_ID_LSB    = 56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_TS,
        ST_DATA,
        ST_WAIT
    } state_t;

    // Two 32-bit lanes per 64-bit word, odd lane count rounds up.
    function automatic logic [2:0] words_per_set(input logic [7:0] mask);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(mask[i]);
        end
        return 3'((cnt + 4'd1) >> 1);
    endfunction

    function automatic logic [63:0] make_header(input logic [7:0]  id,
                                                input logic [7:0]  mask,
                                                input logic [15:0] num,
                                                input logic [31:0] seq);
        logic [63:0] h;
        h = '0;
        h[HDR_ID_LSB   +: 8]  = id;
        h[HDR_MASK_LSB +: 8]  = mask;
        h[HDR_NUM_LSB  +: 16] = num;
        h[HDR_SEQ_LSB  +: 32] = seq;
        return h;
    endfunction

endpackage

// File: rtl/adc_lane_packer.sv
// Builds one 64-bit data word from the active lanes of a held sample set:
// active lanes in ascending order, two sign-extended 32-bit samples per word.
module adc_lane_packer #(
    parameter int NUM_SEL = 4,
    parameter int WIDTH   = 18
) (
    input  logic [NUM_SEL-1:0]       mask,
    input  logic [NUM_SEL*WIDTH-1:0] lanes,
    input  logic [2:0]               word_idx,
    output logic [63:0]              word
);

    int          slot;
    logic [31:0] ext;

    always_comb begin
        word = '0;
        slot = 0;
        ext  = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (mask[i]) begin
                ext = 32'($signed(lanes[i*WIDTH +: WIDTH]));
                if (slot == 2 * int'(word_idx)) begin
                    word[31:0] = ext;
                end else if (slot == 2 * int'(word_idx) + 1) begin
                    word[63:32] = ext;
                end
                slot = slot + 1;
            end
        end
    end

endmodule

// File: rtl/adc_multi_stream.sv
// Selects up to NUM_SEL ADC channels, decimates, and frames sample sets into
// 64-bit stream packets (header, timestamp, data) with a one-set holding register.
//
// state   | meaning
// IDLE    | no packet; a qualifying keep starts one
// HDR     | header word presented
// TS      | timestamp of the first set presented
// DATA    | data words of the held set presented
// WAIT    | set sent, waiting for the next kept sample
module adc_multi_stream
    import adc_stream_pkg::*;
#(
    parameter int          NUM_CH  = 16,
    parameter int          WIDTH   = 18,
    parameter int          NUM_SEL = 4,
    parameter logic [7:0]  ID      = 8'hA5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              block,
    input  logic [NUM_SEL*$clog2(NUM_CH)-1:0] ch_sel,
    input  logic [NUM_SEL-1:0]                sel_mask,
    input  logic [15:0]                       num_samples,
    input  logic [6:0]                        rate_div,
    input  logic                              in_valid,
    input  logic [NUM_CH*WIDTH-1:0]           in_data,
    input  logic [63:0]                       in_ts,
    output logic [63:0]                       fifo_tdata,
    output logic                              fifo_tfirst,
    output logic                              fifo_tlast,
    output logic                              fifo_tvalid,
    input  logic                              fifo_tready,
    output logic [15:0]                       overflow_count,
    output logic                              busy
);

    localparam int CW = $clog2(NUM_CH);

    state_t                   state, state_nxt;
    logic [6:0]               dec_cnt;
    logic                     keep, accept, last_word, capture, drop, tlast_nxt;
    logic                     hold_full, hold_full_nxt;
    logic [NUM_SEL*WIDTH-1:0] hold_data, hold_data_nxt, cap_data;
    logic [63:0]              hold_ts, hold_ts_nxt, data_word, tdata_nxt;
    logic [NUM_SEL-1:0]       mask_l, mask_nxt;
    logic [NUM_SEL*CW-1:0]    ch_sel_l, ch_sel_nxt, ch_src;
    logic [15:0]              num_l, num_nxt, sent, sent_nxt;
    logic [31:0]              seq, seq_nxt;
    logic [2:0]               word_idx, word_idx_nxt, wps, wps_nxt;

    assign keep      = in_valid && (dec_cnt == 7'd0);
    assign accept    = fifo_tvalid && fifo_tready;
    assign wps       = words_per_set(8'(mask_l));
    assign wps_nxt   = words_per_set(8'(mask_nxt));
    assign last_word = (word_idx == wps - 3'd1);
    // The starting sample is captured with the live selection being latched.
    assign ch_src    = (state == ST_IDLE) ? ch_sel : ch_sel_l;

    always_comb begin
        cap_data = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            cap_data[i*WIDTH +: WIDTH] = in_data[int'(ch_src[i*CW +: CW])*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full;
        hold_data_nxt = hold_data;
        hold_ts_nxt   = hold_ts;
        mask_nxt      = mask_l;
        ch_sel_nxt    = ch_sel_l;
        num_nxt       = num_l;
        sent_nxt      = sent;
        seq_nxt       = seq;
        word_idx_nxt  = word_idx;
        capture       = 1'b0;
        drop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (keep && ena && !block && (|sel_mask) && (num_samples != 16'd0)) begin
                    capture      = 1'b1;
                    mask_nxt     = sel_mask;
                    ch_sel_nxt   = ch_sel;
                    num_nxt      = num_samples;
                    sent_nxt     = '0;
                    word_idx_nxt = '0;
                    state_nxt    = ST_HDR;
                end
            end
            ST_HDR: begin
                drop = keep && hold_full;
                if (accept) state_nxt = ST_TS;
            end
            ST_TS: begin
                drop = keep && hold_full;
                if (accept) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (accept && last_word) begin
                    hold_full_nxt = 1'b0;
                    sent_nxt      = sent + 16'd1;
                    word_idx_nxt  = '0;
                    // A keep coinciding with the final word belongs to no packet.
                    if (sent + 16'd1 == num_l) begin
                        seq_nxt   = seq + 32'd1;
                        state_nxt = ST_IDLE;
                    end else if (keep) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else begin
                    drop = keep && hold_full;
                    if (accept) word_idx_nxt = word_idx + 3'd1;
                end
            end
            ST_WAIT: begin
                if (keep) begin
                    capture      = 1'b1;
                    word_idx_nxt = '0;
                    state_nxt    = ST_DATA;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (capture) begin
            hold_full_nxt = 1'b1;
            hold_data_nxt = cap_data;
            hold_ts_nxt   = in_ts;
        end
    end

    adc_lane_packer #(
        .NUM_SEL (NUM_SEL),
        .WIDTH   (WIDTH)
    ) u_packer (
        .mask     (mask_nxt),
        .lanes    (hold_data_nxt),
        .word_idx (word_idx_nxt),
        .word     (data_word)
    );

    // Outputs are a function of next-cycle state, so they hold naturally under stall.
    always_comb begin
        case (state_nxt)
            ST_HDR:  tdata_nxt = make_header(ID, 8'(mask_nxt), num_nxt, seq_nxt);
            ST_TS:   tdata_nxt = hold_ts_nxt;
            ST_DATA: tdata_nxt = data_word;
            default: tdata_nxt = '0;
        endcase
        tlast_nxt = (state_nxt == ST_DATA) && (word_idx_nxt == wps_nxt - 3'd1) &&
                    (sent_nxt + 16'd1 == num_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            dec_cnt        <= '0;
            hold_full      <= 1'b0;
            hold_data      <= '0;
            hold_ts        <= '0;
            mask_l         <= '0;
            ch_sel_l       <= '0;
            num_l          <= '0;
            sent           <= '0;
            seq            <= '0;
            word_idx       <= '0;
            fifo_tdata     <= '0;
            fifo_tfirst    <= 1'b0;
            fifo_tlast     <= 1'b0;
            fifo_tvalid    <= 1'b0;
            overflow_count <= '0;
            busy           <= 1'b0;
        end else begin
            if (in_valid) dec_cnt <= (dec_cnt >= rate_div) ? 7'd0 : dec_cnt + 7'd1;
            state          <= state_nxt;
            hold_full      <= hold_full_nxt;
            hold_data      <= hold_data_nxt;
            hold_ts        <= hold_ts_nxt;
            mask_l         <= mask_nxt;
            ch_sel_l       <= ch_sel_nxt;
            num_l          <= num_nxt;
            sent           <= sent_nxt;
            seq            <= seq_nxt;
            word_idx       <= word_idx_nxt;
            fifo_tdata     <= tdata_nxt;
            fifo_tfirst    <= (state_nxt == ST_HDR);
            fifo_tlast     <= tlast_nxt;
            fifo_tvalid    <= (state_nxt == ST_HDR) || (state_nxt == ST_TS) || (state_nxt == ST_DATA);
            busy           <= (state_nxt != ST_IDLE);
            if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end
    end

endmodule
